// File: rtl/mem_bus_arbiter_pkg.sv
// Shared definitions for the MIO bus arbiter: state encodings and default widths.
package mem_bus_arbiter_pkg;

    localparam int unsigned DEF_ADDR_W       = 32;
    localparam int unsigned DEF_DATA_W       = 32;
    localparam int unsigned DEF_STARVE_LIMIT = 4;
    localparam int unsigned DEF_TIMEOUT      = 255;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_IBUSY = 2'd1,
        ST_DBUSY = 2'd2
    } state_t;

    // Bits needed to hold values 0..max_val.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_watchdog.sv
// Bus transaction watchdog: counts busy cycles and flags expiry at TIMEOUT-1.
module bus_watchdog
    import mem_bus_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT = DEF_TIMEOUT
)(
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic clr,
    output logic expired
);

    localparam int unsigned CW = cnt_width(TIMEOUT);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst || clr) begin
            cnt <= '0;
        end else if (run) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign expired = run && (cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbitrates the single MIO bus between the fetch port and the MEM-stage data port,
// one transaction at a time, data first with a bounded-starvation guard for fetches.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W       = DEF_ADDR_W,
    parameter int unsigned DATA_W       = DEF_DATA_W,
    parameter int unsigned STARVE_LIMIT = DEF_STARVE_LIMIT,
    parameter int unsigned TIMEOUT      = DEF_TIMEOUT
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ack,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ack,
    output logic              stall_if,
    output logic              stall_mem,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic [DATA_W-1:0] bus_rdata,
    input  logic              bus_ready,
    output logic              bus_err
);

    localparam int unsigned SW = cnt_width(STARVE_LIMIT);

    state_t        state;
    state_t        state_next;
    logic [SW-1:0] starve_cnt;
    logic          we_q;
    logic          busy;
    logic          idle;
    logic          grant_d;
    logic          grant_i;
    logic          done_ok;
    logic          done_abort;
    logic          wd_expired;

    assign busy = (state != ST_IDLE);
    assign idle = ~busy;

    bus_watchdog #(
        .TIMEOUT(TIMEOUT)
    ) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .run    (busy),
        .clr    (idle),
        .expired(wd_expired)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Ready is tested before expiry so a ready arriving on the last allowed cycle completes normally.
    always_comb begin
        state_next = state;
        grant_d    = 1'b0;
        grant_i    = 1'b0;
        done_ok    = 1'b0;
        done_abort = 1'b0;
        case (state)
            ST_IDLE: begin
                if (d_req && (!if_req || (starve_cnt < SW'(STARVE_LIMIT)))) begin
                    grant_d    = 1'b1;
                    state_next = ST_DBUSY;
                end else if (if_req) begin
                    grant_i    = 1'b1;
                    state_next = ST_IBUSY;
                end
            end
            ST_IBUSY, ST_DBUSY: begin
                if (bus_ready) begin
                    done_ok    = 1'b1;
                    state_next = ST_IDLE;
                end else if (wd_expired) begin
                    done_abort = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            bus_addr   <= '0;
            bus_wdata  <= '0;
            we_q       <= 1'b0;
            starve_cnt <= '0;
            if_ack     <= 1'b0;
            d_ack      <= 1'b0;
            if_rdata   <= '0;
            d_rdata    <= '0;
            bus_err    <= 1'b0;
        end else begin
            if_ack <= 1'b0;
            d_ack  <= 1'b0;

            if (grant_d) begin
                bus_addr  <= d_addr;
                bus_wdata <= d_wdata;
                we_q      <= d_we;
            end else if (grant_i) begin
                bus_addr  <= if_addr;
                bus_wdata <= '0;
                we_q      <= 1'b0;
            end

            // A data grant over a waiting fetch only happens below the limit, so this never overflows.
            if (grant_d) begin
                starve_cnt <= if_req ? starve_cnt + SW'(1) : '0;
            end else if (grant_i) begin
                starve_cnt <= '0;
            end

            if (done_ok || done_abort) begin
                if (state == ST_IBUSY) begin
                    if_ack   <= 1'b1;
                    if_rdata <= done_ok ? bus_rdata : '0;
                end else begin
                    d_ack   <= 1'b1;
                    d_rdata <= done_ok ? bus_rdata : '0;
                end
            end

            if (done_abort) begin
                bus_err <= 1'b1;
            end
        end
    end

    assign bus_req   = busy;
    assign bus_we    = (state == ST_DBUSY) && we_q;
    assign stall_if  = if_req & ~if_ack;
    assign stall_mem = d_req & ~d_ack;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed scenarios plus randomized traffic
// against a transaction-level reference model and a simple bus slave.
module tb_mem_bus_arbiter;

    localparam int unsigned AW   = 32;
    localparam int unsigned DW   = 32;
    localparam int unsigned SLIM = 4;
    localparam int unsigned TMO  = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          if_req = 1'b0;
    logic [31:0]   if_addr = '0;
    logic [31:0]   if_rdata;
    logic          if_ack;
    logic          d_req = 1'b0;
    logic          d_we = 1'b0;
    logic [31:0]   d_addr = '0;
    logic [31:0]   d_wdata = '0;
    logic [31:0]   d_rdata;
    logic          d_ack;
    logic          stall_if;
    logic          stall_mem;
    logic          bus_req;
    logic          bus_we;
    logic [31:0]   bus_addr;
    logic [31:0]   bus_wdata;
    logic [31:0]   bus_rdata = '0;
    logic          bus_ready = 1'b0;
    logic          bus_err;

    int checks = 0;
    int errors = 0;

    mem_bus_arbiter #(
        .ADDR_W      (AW),
        .DATA_W      (DW),
        .STARVE_LIMIT(SLIM),
        .TIMEOUT     (TMO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_rdata (if_rdata),
        .if_ack   (if_ack),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_rdata  (d_rdata),
        .d_ack    (d_ack),
        .stall_if (stall_if),
        .stall_mem(stall_mem),
        .bus_req  (bus_req),
        .bus_we   (bus_we),
        .bus_addr (bus_addr),
        .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata),
        .bus_ready(bus_ready),
        .bus_err  (bus_err)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void chkb(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void chks(input string name, input string act, input string exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got \"%s\" expected \"%s\"", name, act, exp);
        end
    endfunction

    // Contents of any location never written.
    function automatic logic [31:0] mem_init(input logic [31:0] a);
        return ~a ^ 32'h1234_5678;
    endfunction

    // ---------------- bus slave ----------------
    logic [31:0] slave_mem [logic [31:0]];
    int unsigned ready_delay = 0;
    bit          rnd_delay   = 1'b0;
    int unsigned slave_age   = 0;
    int unsigned cur_delay   = 0;

    always @(posedge clk) begin
        if (rst && bus_req && bus_we && bus_ready) slave_mem[bus_addr] = bus_wdata;
        #1;
        if (bus_req) begin
            if (slave_age == 0) begin
                if (rnd_delay)
                    cur_delay = ($urandom_range(0, 4) == 0) ? $urandom_range(6, 9) : $urandom_range(0, 2);
                else
                    cur_delay = ready_delay;
            end
            bus_ready = (slave_age == cur_delay);
            slave_age++;
        end else begin
            slave_age = 0;
            bus_ready = rnd_delay ? ($urandom_range(0, 1) == 1) : 1'b0;
        end
        bus_rdata = slave_mem.exists(bus_addr) ? slave_mem[bus_addr] : mem_init(bus_addr);
    end

    // ---------------- reference model (one transaction at a time) ----------------
    logic [31:0] model_mem [logic [31:0]];
    bit          m_started = 1'b0;
    bit          m_busy = 1'b0;
    bit          m_port_d = 1'b0;
    bit          m_we = 1'b0;
    bit          m_err = 1'b0;
    bit          m_if_ack = 1'b0;
    bit          m_d_ack = 1'b0;
    logic [31:0] m_addr = '0;
    logic [31:0] m_wdata = '0;
    logic [31:0] m_if_rdata = '0;
    logic [31:0] m_d_rdata = '0;
    logic [31:0] m_rd = '0;
    int unsigned m_waited = 0;
    int unsigned m_starve = 0;

    always @(posedge clk) begin
        m_started = 1'b1;
        m_if_ack  = 1'b0;
        m_d_ack   = 1'b0;
        if (!rst) begin
            m_busy     = 1'b0;
            m_err      = 1'b0;
            m_starve   = 0;
            m_if_rdata = '0;
            m_d_rdata  = '0;
        end else if (m_busy) begin
            if (bus_ready || m_waited == TMO - 1) begin
                if (bus_ready) begin
                    m_rd = model_mem.exists(m_addr) ? model_mem[m_addr] : mem_init(m_addr);
                    if (m_port_d && m_we) model_mem[m_addr] = m_wdata;
                end else begin
                    m_rd  = '0;
                    m_err = 1'b1;
                end
                if (m_port_d) begin
                    m_d_ack   = 1'b1;
                    m_d_rdata = m_rd;
                end else begin
                    m_if_ack   = 1'b1;
                    m_if_rdata = m_rd;
                end
                m_busy = 1'b0;
            end else begin
                m_waited++;
            end
        end else if (d_req && (!if_req || m_starve < SLIM)) begin
            m_busy   = 1'b1;
            m_port_d = 1'b1;
            m_we     = d_we;
            m_addr   = d_addr;
            m_wdata  = d_wdata;
            m_waited = 0;
            m_starve = if_req ? ((m_starve < SLIM) ? m_starve + 1 : SLIM) : 0;
        end else if (if_req) begin
            m_busy   = 1'b1;
            m_port_d = 1'b0;
            m_we     = 1'b0;
            m_addr   = if_addr;
            m_waited = 0;
            m_starve = 0;
        end
    end

    always @(negedge clk) begin
        if (m_started) begin
            chkb("bus_req", bus_req, m_busy);
            chkb("bus_we", bus_we, m_busy && m_port_d && m_we);
            if (m_busy) chk("bus_addr", bus_addr, m_addr);
            if (m_busy && m_port_d && m_we) chk("bus_wdata", bus_wdata, m_wdata);
            chkb("if_ack", if_ack, m_if_ack);
            chkb("d_ack", d_ack, m_d_ack);
            chk("if_rdata", if_rdata, m_if_rdata);
            chk("d_rdata", d_rdata, m_d_rdata);
            chkb("bus_err", bus_err, m_err);
            chkb("stall_if", stall_if, if_req && !m_if_ack);
            chkb("stall_mem", stall_mem, d_req && !m_d_ack);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [31:0] rand_addr();
        return 32'($urandom_range(0, 15)) << 2;
    endfunction

    initial begin
        #1_000_000;
        errors++;
        $display("FAIL global_timeout: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "time limit");
    end

    initial begin
        int          n;
        int          ackc [3];
        logic [31:0] got [3];
        bit          flag;
        bit          stall_bad;
        bit          chk_next_fetch;
        string       order;
        int          nload;
        int          breq;
        int          rdy_cyc;
        int          ack_cyc;
        logic [31:0] got1;

        repeat (3) tick();
        chkb("reset_bus_req", bus_req, 1'b0);
        chkb("reset_bus_err", bus_err, 1'b0);
        chkb("reset_d_ack", d_ack, 1'b0);
        chk("reset_d_rdata", d_rdata, 32'h0);
        rst = 1'b1;
        tick();

        // 1: fetch-only stream on a zero-wait bus
        ready_delay = 0;
        n = 0;
        flag = 1'b0;
        for (int i = 0; i < 3; i++) begin ackc[i] = 0; got[i] = '0; end
        if_req = 1'b1;
        if_addr = 32'h0;
        for (int cyc = 0; cyc < 40 && n < 3; cyc++) begin
            tick();
            if (bus_we) flag = 1'b1;
            if (if_ack) begin
                got[n] = if_rdata;
                ackc[n] = cyc;
                n++;
                if (n < 3) if_addr = 32'(n * 4);
                else if_req = 1'b0;
            end
        end
        chk("t1_ack_count", n, 3);
        chk("t1_rdata0", got[0], 32'hEDCB_A987);
        chk("t1_rdata1", got[1], 32'hEDCB_A983);
        chk("t1_rdata2", got[2], 32'hEDCB_A98F);
        chk("t1_spacing01", ackc[1] - ackc[0], 2);
        chk("t1_spacing12", ackc[2] - ackc[1], 2);
        chkb("t1_no_bus_we", flag, 1'b0);
        repeat (2) tick();

        // 2: simultaneous store and fetch
        if_req = 1'b1; if_addr = 32'hC;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'hDEAD_BEEF;
        tick();
        chkb("t2_bus_we", bus_we, 1'b1);
        chk("t2_bus_addr", bus_addr, 32'h100);
        order = "";
        chk_next_fetch = 1'b0;
        for (int cyc = 0; cyc < 20 && order.len() < 2; cyc++) begin
            tick();
            if (chk_next_fetch) begin
                chkb("t2_fetch_follows", bus_req, 1'b1);
                chk("t2_fetch_addr", bus_addr, 32'hC);
                chk_next_fetch = 1'b0;
            end
            if (d_ack) begin order = {order, "D"}; d_req = 1'b0; d_we = 1'b0; chk_next_fetch = 1'b1; end
            if (if_ack) begin order = {order, "I"}; if_req = 1'b0; end
        end
        chks("t2_order", order, "DI");
        chk("t2_mem_written", slave_mem.exists(32'h100) ? slave_mem[32'h100] : 32'h0, 32'hDEAD_BEEF);
        repeat (2) tick();

        // 3: continuous loads with a fetch waiting
        if_req = 1'b1; if_addr = 32'h20;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200;
        nload = 0; order = ""; stall_bad = 1'b0;
        for (int cyc = 0; cyc < 60 && order.len() < 6; cyc++) begin
            tick();
            if (if_req && !if_ack && !stall_if) stall_bad = 1'b1;
            if (d_ack) begin
                order = {order, "D"};
                nload++;
                if (nload < 5) d_addr = 32'h200 + 32'(nload * 4);
                else d_req = 1'b0;
            end
            if (if_ack) begin order = {order, "I"}; if_req = 1'b0; end
        end
        chks("t3_grant_order", order, "DDDDID");
        chkb("t3_stall_if_held", stall_bad, 1'b0);
        repeat (2) tick();

        // 4: load with three wait cycles
        ready_delay = 3;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300;
        breq = 0; rdy_cyc = -1; ack_cyc = -1; stall_bad = 1'b0; got1 = '0;
        for (int cyc = 0; cyc < 30 && ack_cyc < 0; cyc++) begin
            tick();
            if (bus_req) breq++;
            if (bus_req && bus_ready && rdy_cyc < 0) rdy_cyc = cyc;
            if (d_ack) begin ack_cyc = cyc; got1 = d_rdata; d_req = 1'b0; end
            else if (!stall_mem) stall_bad = 1'b1;
        end
        chk("t4_bus_req_cycles", breq, 4);
        chk("t4_ack_after_ready", ack_cyc - rdy_cyc, 1);
        chk("t4_rdata", got1, 32'hEDCB_AA87);
        chkb("t4_stall_mem_held", stall_bad, 1'b0);
        repeat (2) tick();

        // 5: bus never ready -> watchdog abort
        ready_delay = 1000;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h400;
        breq = 0; flag = 1'b0; got1 = 32'hFFFF_FFFF;
        for (int cyc = 0; cyc < 40 && !flag; cyc++) begin
            tick();
            if (bus_req) breq++;
            if (d_ack) begin flag = 1'b1; got1 = d_rdata; d_req = 1'b0; end
        end
        chkb("t5_abort_ack", flag, 1'b1);
        chk("t5_bus_cycles", breq, 8);
        chk("t5_abort_rdata", got1, 32'h0);
        chkb("t5_bus_err", bus_err, 1'b1);
        repeat (5) tick();
        chkb("t5_bus_err_sticky", bus_err, 1'b1);

        // 6: reset in the second D_BUSY cycle
        ready_delay = 10;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'h0000_1234;
        tick();
        chkb("t6_busy", bus_req, 1'b1);
        tick();
        rst = 1'b0; d_req = 1'b0; d_we = 1'b0;
        tick();
        chkb("t6_bus_req", bus_req, 1'b0);
        chkb("t6_no_ack", d_ack, 1'b0);
        chkb("t6_bus_err", bus_err, 1'b0);
        rst = 1'b1;
        tick();
        chkb("t6_no_ack_after", d_ack, 1'b0);
        chkb("t6_idle_after", bus_req, 1'b0);

        // random traffic
        rnd_delay = 1'b1;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            tick();
            if (!rst) begin
                rst = 1'b1;
            end else if ($urandom_range(0, 599) == 0) begin
                rst = 1'b0; if_req = 1'b0; d_req = 1'b0;
            end else begin
                if (if_ack) begin
                    if ($urandom_range(0, 1) == 1) if_addr = rand_addr();
                    else if_req = 1'b0;
                end else if (!if_req && $urandom_range(0, 3) == 0) begin
                    if_req = 1'b1; if_addr = rand_addr();
                end
                if (d_ack) begin
                    if ($urandom_range(0, 1) == 1) begin
                        d_addr = rand_addr(); d_we = ($urandom_range(0, 1) == 1); d_wdata = $urandom;
                    end else begin
                        d_req = 1'b0;
                    end
                end else if (!d_req && $urandom_range(0, 2) == 0) begin
                    d_req = 1'b1; d_addr = rand_addr(); d_we = ($urandom_range(0, 1) == 1); d_wdata = $urandom;
                end
            end
        end
        rst = 1'b1; if_req = 1'b0; d_req = 1'b0;
        repeat (20) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
